microsequencer: RTL

MICROSEQUENCER -- requirements
Module: microsequencer

---
 rtl/microsequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/microsequencer.sv
// Microstore next-address sequencer: decode/increment/jump/branch/wait/call/return.
// Optional return stack enabled by defining MICROSEQ_RETURN_STACK_EN.
module microsequencer #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        ns_type,
  input  logic [1:0]        cond_sel,
  input  logic              inv,
  input  logic [ADDR_W-1:0] cr_addr,
  input  logic [ADDR_W-1:0] decoded_state,
  input  logic [3:0]        cond,
  input  logic              moc,
  output logic [ADDR_W-1:0] next_state,
  output logic              stack_err
);

  typedef enum logic [2:0] {
    NS_DECODE = 3'b000,
    NS_INC    = 3'b001,
    NS_JUMP   = 3'b010,
    NS_BRANCH = 3'b011,
    NS_WAIT   = 3'b100,
    NS_CALL   = 3'b101,
    NS_RETURN = 3'b110,
    NS_RSVD   = 3'b111
  } ns_t;

  ns_t               ns;
  logic [ADDR_W-1:0] s_inc;
  logic              cond_hit;
  logic [ADDR_W-1:0] addr_d;

  assign ns       = ns_t'(ns_type);
  assign s_inc    = next_state + ADDR_W'(1);
  assign cond_hit = cond[cond_sel] ^ inv;

`ifdef MICROSEQ_RETURN_STACK_EN
  localparam int unsigned PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(STACK_DEPTH);

  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
  logic [PTR_W:0]    depth;
  logic [PTR_W-1:0]  top_idx;
  logic              is_full;
  logic              is_empty;
  logic              do_push;
  logic              do_pop;
  logic              err_set;

  assign is_full  = (depth == FULL_LVL);
  assign is_empty = (depth == '0);
  // Depth is a power of two, so the low bits of a full counter wrap to 0 and top_idx stays valid.
  assign top_idx  = depth[PTR_W-1:0] - PTR_W'(1);
  assign do_push  = (ns == NS_CALL)   && !is_full;
  assign do_pop   = (ns == NS_RETURN) && !is_empty;
  assign err_set  = ((ns == NS_CALL) && is_full) || ((ns == NS_RETURN) && is_empty);

  always_comb begin
    addr_d = next_state;
    case (ns)
      NS_DECODE: addr_d = decoded_state;
      NS_INC:    addr_d = s_inc;
      NS_JUMP:   addr_d = cr_addr;
      NS_BRANCH: addr_d = cond_hit ? cr_addr : s_inc;
      NS_WAIT:   addr_d = moc ? s_inc : next_state;
      NS_CALL:   addr_d = cr_addr;
      NS_RETURN: addr_d = is_empty ? '0 : stack_mem[top_idx];
      NS_RSVD:   addr_d = '0;
      default:   addr_d = '0;
    endcase
  end

  // Entries carry no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (!reset && do_push)
      stack_mem[depth[PTR_W-1:0]] <= s_inc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      next_state <= '0;
      depth      <= '0;
      stack_err  <= 1'b0;
    end else begin
      next_state <= addr_d;
      if (do_push)
        depth <= depth + (PTR_W+1)'(1);
      else if (do_pop)
        depth <= depth - (PTR_W+1)'(1);
      if (err_set)
        stack_err <= 1'b1;
    end
  end
`else
  always_comb begin
    addr_d = next_state;
    case (ns)
      NS_DECODE: addr_d = decoded_state;
      NS_INC:    addr_d = s_inc;
      NS_JUMP:   addr_d = cr_addr;
      NS_BRANCH: addr_d = cond_hit ? cr_addr : s_inc;
      NS_WAIT:   addr_d = moc ? s_inc : next_state;
      NS_CALL:   addr_d = '0;
      NS_RETURN: addr_d = '0;
      NS_RSVD:   addr_d = '0;
      default:   addr_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      next_state <= '0;
    else
      next_state <= addr_d;
  end

  assign stack_err = 1'b0;
`endif

endmodule
